slab_interval_sequencer: RTL and testbench

- Initiator side of the FP greater-or-equal compare interface. It consumes per-axis slab entry/exit times (tnear_x/y/z, tfar_x/y/z) in the 11-4 FloPoCo format: 18 bits = exn[17:16], sign[15], exp[14:11], frac[10:0].
- It issues compares to an external greater-or-equal comparator, one at a time, and reduces the results:
  - t_enter = max(tnear)
  - t_exit = min(tfar)
  - hit = (t_exit >= t_enter)
- It sits between the per-axis slab subtract/multiply stage and the hit output of the Ray-AABB core.

---
 rtl/rabb_fp_pkg.sv | 47 ++++
 rtl/slab_interval_sequencer.sv | 154 +++++++++++++++
 tb/tb_slab_interval_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rabb_fp_pkg.sv
// Shared definitions for the Ray-AABB FP datapath: the 11-4 FloPoCo operand layout,
// exception codes, sequencer state encodings and a handful of reference constants.
package rabb_fp_pkg;

  localparam int unsigned FP_W     = 18;
  localparam int unsigned EXN_MSB  = 17;
  localparam int unsigned SIGN     = 15;
  localparam int unsigned EXP_MSB  = 14;
  localparam int unsigned FRAC_MSB = 10;

  localparam logic [1:0] EXN_ZERO   = 2'b00;
  localparam logic [1:0] EXN_NORMAL = 2'b01;
  localparam logic [1:0] EXN_INF    = 2'b10;
  localparam logic [1:0] EXN_NAN    = 2'b11;

  localparam logic [1:0] ST_IDLE_ENC = 2'b00;
  localparam logic [1:0] ST_CMP_ENC  = 2'b01;
  localparam logic [1:0] ST_DONE_ENC = 2'b10;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE_ENC,
    StCmp  = ST_CMP_ENC,
    StDone = ST_DONE_ENC
  } state_e;

  // One compare per step: two for max(tnear), two for min(tfar), one for the overlap test.
  typedef enum logic [2:0] {
    StepNearXy = 3'd0,
    StepNearZ  = 3'd1,
    StepFarXy  = 3'd2,
    StepFarZ   = 3'd3,
    StepHit    = 3'd4
  } step_e;

  localparam logic [FP_W-1:0] FP_ZERO  = 18'h00000;
  localparam logic [FP_W-1:0] FP_HALF  = 18'h13000;
  localparam logic [FP_W-1:0] FP_ONE   = 18'h13800;
  localparam logic [FP_W-1:0] FP_TWO   = 18'h14000;
  localparam logic [FP_W-1:0] FP_THREE = 18'h14400;
  localparam logic [FP_W-1:0] FP_FOUR  = 18'h14800;
  localparam logic [FP_W-1:0] FP_NAN   = 18'h30000;

  function automatic logic is_nan(input logic [FP_W-1:0] v);
    return v[EXN_MSB -: 2] == EXN_NAN;
  endfunction

endpackage

// File: rtl/slab_interval_sequencer.sv
// Reduces per-axis slab times to [t_enter, t_exit] and a hit flag by issuing five
// sequential compares to an external greater-or-equal unit with fixed latency.
module slab_interval_sequencer #(
  parameter int unsigned FP_W        = rabb_fp_pkg::FP_W,
  parameter int unsigned CMP_LATENCY = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] tnear_x,
  input  logic [FP_W-1:0] tnear_y,
  input  logic [FP_W-1:0] tnear_z,
  input  logic [FP_W-1:0] tfar_x,
  input  logic [FP_W-1:0] tfar_y,
  input  logic [FP_W-1:0] tfar_z,
  output logic [FP_W-1:0] cmp_a,
  output logic [FP_W-1:0] cmp_b,
  input  logic            cmp_ge,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            hit,
  output logic [FP_W-1:0] t_enter,
  output logic [FP_W-1:0] t_exit
);
  import rabb_fp_pkg::*;

  localparam logic [3:0] CntMax = 4'(CMP_LATENCY);

  state_e          state_q;
  step_e           step_q;
  logic [3:0]      cnt_q;
  logic [FP_W-1:0] tnear_z_q;
  logic [FP_W-1:0] tfar_x_q;
  logic [FP_W-1:0] tfar_y_q;
  logic [FP_W-1:0] tfar_z_q;
  logic [FP_W-1:0] cmp_a_q;
  logic [FP_W-1:0] cmp_b_q;
  logic [FP_W-1:0] t_enter_q;
  logic [FP_W-1:0] t_exit_q;
  logic            hit_q;
  logic            out_valid_q;

  logic            any_nan;
  logic [FP_W-1:0] max_v;
  logic [FP_W-1:0] min_v;

  always_comb begin
    any_nan = is_nan(tnear_x) | is_nan(tnear_y) | is_nan(tnear_z) |
              is_nan(tfar_x)  | is_nan(tfar_y)  | is_nan(tfar_z);
    // Ties keep the first operand for max and the second for min, so equal bounds hit.
    max_v   = cmp_ge ? cmp_a_q : cmp_b_q;
    min_v   = cmp_ge ? cmp_b_q : cmp_a_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      step_q      <= StepNearXy;
      cnt_q       <= '0;
      tnear_z_q   <= '0;
      tfar_x_q    <= '0;
      tfar_y_q    <= '0;
      tfar_z_q    <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      t_enter_q   <= '0;
      t_exit_q    <= '0;
      hit_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            tnear_z_q <= tnear_z;
            tfar_x_q  <= tfar_x;
            tfar_y_q  <= tfar_y;
            tfar_z_q  <= tfar_z;
            if (any_nan) begin
              // Comparator is never engaged for a NaN bundle; operands keep their values.
              hit_q       <= 1'b0;
              t_enter_q   <= tnear_x;
              t_exit_q    <= tfar_x;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              cmp_a_q <= tnear_x;
              cmp_b_q <= tnear_y;
              step_q  <= StepNearXy;
              cnt_q   <= '0;
              state_q <= StCmp;
            end
          end
        end

        StCmp: begin
          if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 4'd1;
          end else begin
            cnt_q <= '0;
            unique case (step_q)
              StepNearXy: begin
                cmp_a_q <= max_v;
                cmp_b_q <= tnear_z_q;
                step_q  <= StepNearZ;
              end
              StepNearZ: begin
                t_enter_q <= max_v;
                cmp_a_q   <= tfar_x_q;
                cmp_b_q   <= tfar_y_q;
                step_q    <= StepFarXy;
              end
              StepFarXy: begin
                cmp_a_q <= min_v;
                cmp_b_q <= tfar_z_q;
                step_q  <= StepFarZ;
              end
              StepFarZ: begin
                t_exit_q <= min_v;
                cmp_a_q  <= min_v;
                cmp_b_q  <= t_enter_q;
                step_q   <= StepHit;
              end
              StepHit: begin
                hit_q       <= cmp_ge;
                out_valid_q <= 1'b1;
                state_q     <= StDone;
              end
              default: state_q <= StIdle;
            endcase
          end
        end

        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign cmp_a     = cmp_a_q;
  assign cmp_b     = cmp_b_q;
  assign out_valid = out_valid_q;
  assign hit       = hit_q;
  assign t_enter   = t_enter_q;
  assign t_exit    = t_exit_q;

endmodule

// File: tb/tb_slab_interval_sequencer.sv
// Directed bench for slab_interval_sequencer with a behavioural 3-cycle FP >= comparator
// and a result scoreboard filled at accept time and drained at each output handshake.
module tb_slab_interval_sequencer;
  import rabb_fp_pkg::*;

  localparam int unsigned LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [FP_W-1:0] tnear_x, tnear_y, tnear_z;
  logic [FP_W-1:0] tfar_x, tfar_y, tfar_z;
  logic [FP_W-1:0] cmp_a, cmp_b;
  logic            cmp_ge;
  logic            out_valid;
  logic            out_ready;
  logic            hit;
  logic [FP_W-1:0] t_enter, t_exit;

  always #5 clk = ~clk;

  slab_interval_sequencer #(
    .FP_W        (FP_W),
    .CMP_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tnear_x   (tnear_x),
    .tnear_y   (tnear_y),
    .tnear_z   (tnear_z),
    .tfar_x    (tfar_x),
    .tfar_y    (tfar_y),
    .tfar_z    (tfar_z),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_ge    (cmp_ge),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hit       (hit),
    .t_enter   (t_enter),
    .t_exit    (t_exit)
  );

  // Signed ordering key: zero ignores sign, infinity exceeds every normal.
  function automatic logic signed [18:0] fp_key(input logic [FP_W-1:0] v);
    logic signed [18:0] m;
    case (v[EXN_MSB -: 2])
      EXN_ZERO:   m = '0;
      EXN_NORMAL: m = {4'b0001, v[EXP_MSB:FRAC_MSB+1], v[FRAC_MSB:0]};
      EXN_INF:    m = 19'sh10000;
      default:    m = '0;
    endcase
    return v[SIGN] ? -m : m;
  endfunction

  // Comparator model: not reset, so stale in-flight results persist across a DUT reset.
  logic [LAT-1:0] ge_pipe = '0;
  always @(posedge clk) ge_pipe <= {ge_pipe[LAT-2:0], fp_key(cmp_a) >= fp_key(cmp_b)};
  assign cmp_ge = ge_pipe[LAT-1];

  typedef struct packed {
    logic            hit;
    logic [FP_W-1:0] t_enter;
    logic [FP_W-1:0] t_exit;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   edges;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic [FP_W-1:0] nx, ny, nz, fx, fy, fz);
    tnear_x = nx; tnear_y = ny; tnear_z = nz;
    tfar_x  = fx; tfar_y  = fy; tfar_z  = fz;
  endtask

  // Presents a bundle, returns #1 after its accept edge.
  task automatic drive(input logic [FP_W-1:0] nx, ny, nz, fx, fy, fz, input logic keep,
                       input logic push, input logic eh, input logic [FP_W-1:0] ete, etx);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1);
    set_inputs(nx, ny, nz, fx, fy, fz);
    in_valid = 1'b1;
    if (push) sb.push_back('{hit: eh, t_enter: ete, t_exit: etx});
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int e);
    e = 0;
    while (!out_valid && e < 200) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic consume(input string tag);
    exp_t x;
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    check({tag, "_out_valid"}, out_valid, 1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check({tag, "_hit"}, hit, x.hit);
      check({tag, "_t_enter"}, t_enter, x.t_enter);
      check({tag, "_t_exit"}, t_exit, x.t_exit);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_inputs('0, '0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_hit", hit, 0);
    check("rst_t_enter", t_enter, 0);
    check("rst_t_exit", t_exit, 0);
    check("rst_cmp_a", cmp_a, 0);
    check("rst_cmp_b", cmp_b, 0);
    check("rst_in_ready", in_ready, 1);

    // NaN short-circuit: result in the cycle after accept, comparator untouched.
    drive(FP_ONE, FP_NAN, FP_ZERO, FP_THREE, FP_FOUR, FP_TWO, 0, 1, 0, FP_ONE, FP_THREE);
    wait_out(edges);
    check("nan_latency", edges, 0);
    check("nan_cmp_a", cmp_a, 0);
    check("nan_cmp_b", cmp_b, 0);
    check("nan_in_ready", in_ready, 0);
    consume("nan");

    drive(FP_HALF, FP_ONE, FP_ZERO, FP_THREE, FP_FOUR, FP_TWO, 0, 1, 1, FP_ONE, FP_TWO);
    wait_out(edges);
    check("hit_latency", edges, 5 * (LAT + 1));
    consume("hit");

    drive(FP_TWO, FP_THREE, FP_HALF, FP_FOUR, FP_ONE, FP_FOUR, 0, 1, 0, FP_THREE, FP_ONE);
    wait_out(edges);
    check("miss_latency", edges, 20);
    consume("miss");

    drive(FP_ONE, FP_ONE, FP_ONE, FP_ONE, FP_ONE, FP_ONE, 0, 1, 1, FP_ONE, FP_ONE);
    wait_out(edges);
    check("tie_latency", edges, 20);
    consume("tie");

    // Backpressure with in_valid held high; second bundle waits for the handshake.
    drive(FP_FOUR, FP_HALF, FP_ONE, FP_TWO, FP_THREE, FP_FOUR, 1, 1, 0, FP_FOUR, FP_TWO);
    set_inputs(FP_ZERO, FP_ZERO, FP_ZERO, FP_HALF, FP_HALF, FP_HALF);
    sb.push_back('{hit: 1'b1, t_enter: FP_ZERO, t_exit: FP_HALF});
    wait_out(edges);
    check("bp1_latency", edges, 20);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_hit", hit, 0);
      check("bp_hold_t_enter", t_enter, FP_FOUR);
      check("bp_hold_t_exit", t_exit, FP_TWO);
    end
    consume("bp1");
    @(posedge clk);
    #1;
    check("bp2_accepted", in_ready, 0);
    in_valid = 1'b0;
    wait_out(edges);
    check("bp2_latency", edges, 20);
    consume("bp2");

    // Reset during step 2; hit still holds 1 from the previous result.
    drive(FP_TWO, FP_THREE, FP_HALF, FP_FOUR, FP_ONE, FP_FOUR, 0, 0, 0, FP_ZERO, FP_ZERO);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("abort_step2_cmp_a", cmp_a, FP_FOUR);
    check("abort_step2_cmp_b", cmp_b, FP_ONE);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_hit", hit, 0);
    check("abort_in_ready", in_ready, 1);
    drive(FP_ZERO, FP_TWO, FP_HALF, FP_THREE, FP_FOUR, FP_FOUR, 0, 1, 1, FP_TWO, FP_THREE);
    wait_out(edges);
    check("post_abort_latency", edges, 20);
    consume("post_abort");
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
